alu_result_serializer: RTL
==========================

Name: alu_result_serializer

Overview:
- Reads the registered ALU result and its valid flag, splits the result into DATA_WIDTH-bit frames, and hands them one at a time to the UART transmitter over a valid/ready handshake.
- Sits between the ALU output register stage and the UART TX.
- Single clock domain.
- Provides an optional programmable idle gap between frames.
- Reports a sticky overrun when a new result arrives while a transfer is still in progress.

Parameters:
- DATA_WIDTH, 8: UART frame width in bits.
- RESULT_WIDTH, 16: ALU result width. Must be an integer multiple of DATA_WIDTH, with ratio ≥ 1.
- MSB_FIRST, 0: 0 sends the least-significant frame first; 1 sends the most-significant frame first.
- GAP_CYCLES, 0: idle clock cycles inserted after each accepted frame. Allowed range 0..255.

Ports:
- clk, input, 1: block clock.
- rst, input, 1: reset. **Synchronous, active-high.**
- RESULT, input, RESULT_WIDTH: ALU result word.
- RESULT_VLD, input, 1: RESULT is valid this cycle. Level-sampled on each edge.
- TX_RDY, input, 1: UART TX can accept a frame this cycle.
- CLR_OVR, input, 1: clears OVERRUN.
- TX_DATA, output, DATA_WIDTH: current frame.
- TX_VLD, output, 1: TX_DATA is valid.
- BUSY, output, 1: a result is held and not yet fully sent.
- DONE, output, 1: one-cycle pulse after the last frame is accepted.
- OVERRUN, output, 1: sticky flag; a result was dropped.

Behaviour:
- Definitions:
  - NUM_FRAMES = RESULT_WIDTH/DATA_WIDTH.
  - A handshake occurs on any edge where TX_VLD=1 and TX_RDY=1.
- Reset:
  - On any edge with rst=1: state goes to IDLE.
  - TX_DATA=0, TX_VLD=0, BUSY=0, DONE=0, OVERRUN=0.
  - The held word and the frame index are cleared.
  - Reset mid-transfer discards the word. No further frames are presented.
- FSM states: IDLE, SEND, GAP. All outputs are registered.
- IDLE:
  - TX_VLD=0, BUSY=0.
  - On an edge with RESULT_VLD=1: capture RESULT into the hold register, set index=0, go to SEND.
  - On that same edge, load TX_DATA with the first frame and set TX_VLD=1 and BUSY=1.
  - Latency: RESULT_VLD sampled at edge N gives TX_VLD=1 in the cycle after edge N.
- Frame selection:
  - Frame k is bits [k*DATA_WIDTH +: DATA_WIDTH] when MSB_FIRST=0.
  - Frame k is frame (NUM_FRAMES-1-k) when MSB_FIRST=1.
- SEND:
  - TX_VLD and TX_DATA hold steady until a handshake occurs. TX_DATA must not change while TX_VLD=1 and TX_RDY=0.
  - On a handshake that is not the last frame:
    - index increments.
    - If GAP_CYCLES=0: TX_DATA loads the next frame and TX_VLD stays 1, giving back-to-back frames.
    - Otherwise: TX_VLD=0, the gap counter loads GAP_CYCLES, and the FSM goes to GAP.
  - On the handshake of the last frame (index=NUM_FRAMES-1):
    - TX_VLD=0, BUSY=0, DONE=1 for exactly one cycle.
    - FSM goes to IDLE. GAP is not applied after the last frame.
- GAP:
  - The counter decrements each cycle.
  - When the count reaches 1, the next edge loads the next frame, sets TX_VLD=1 and returns to SEND.
  - The gap is exactly GAP_CYCLES cycles with TX_VLD=0.
- Overrun:
  - RESULT_VLD=1 on an edge while in SEND or GAP means the new word is dropped and OVERRUN is set to 1.
  - This includes the edge on which the last frame's handshake occurs. A new result is accepted only from IDLE, so the earliest accept is the edge after DONE rises.
  - The held word and the in-progress transfer are unaffected.
  - CLR_OVR=1 clears OVERRUN on the next edge. If set and clear happen on the same edge, set wins.
- NUM_FRAMES=1: the first handshake is also the last, giving DONE after one frame.
- The index counter is $clog2(NUM_FRAMES) bits wide, minimum 1.
- The index never wraps within one transfer.
- TX_RDY is ignored while TX_VLD=0.

Test Plan:
1. Defaults, TX_RDY held 1: RESULT=16'hA55A with a one-cycle RESULT_VLD -> TX_DATA=8'h5A then 8'hA5 on consecutive cycles. DONE pulses 1 cycle after the second handshake. BUSY is 1 for exactly 2 cycles.
2. MSB_FIRST=1, GAP_CYCLES=3, TX_RDY=1: RESULT=16'h1234 -> frames 8'h12, then 3 cycles of TX_VLD=0, then 8'h34, then DONE.
3. Backpressure: TX_RDY=0 for 5 cycles after TX_VLD rises on RESULT=16'hBEEF -> TX_DATA stays 8'hEF and TX_VLD stays 1 for 5 cycles. Releasing TX_RDY sends 8'hEF then 8'hBE.
4. Overrun:
   - A second RESULT_VLD with 16'h0F0F during SEND of 16'h1111 -> only 8'h11, 8'h11 are sent, and OVERRUN=1 stays set.
   - CLR_OVR together with a new RESULT_VLD during SEND -> OVERRUN remains 1.
   - CLR_OVR alone -> OVERRUN returns to 0.
5. Reset mid-operation: assert rst for 1 cycle after the first frame of 16'hCAFE -> all outputs are 0 on the next cycle and no 8'hCA is ever presented. A new RESULT=16'h0001 afterwards sends 8'h01, 8'h00 normally.
6. RESULT_VLD on the same edge as the final handshake -> word dropped and OVERRUN=1. RESULT_VLD one cycle later (IDLE) -> accepted.

Source files
------------

// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - splits a registered ALU result into UART-width frames over valid/ready
module alu_result_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int MSB_FIRST    = 0,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RESULT_WIDTH-1:0] RESULT,
    input  logic                    RESULT_VLD,
    input  logic                    TX_RDY,
    input  logic                    CLR_OVR,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VLD,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    OVERRUN
);

    localparam int NUM_FRAMES = RESULT_WIDTH / DATA_WIDTH;
    localparam int IDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                  state;
    logic [RESULT_WIDTH-1:0] hold;
    logic [IDX_W-1:0]        idx;
    logic [7:0]              gap_cnt;

    // Frame k in transmit order; MSB_FIRST reverses the slice order.
    function automatic logic [DATA_WIDTH-1:0] frame_of(
        input logic [RESULT_WIDTH-1:0] word,
        input int                      k
    );
        int sel;
        sel = (MSB_FIRST != 0) ? (NUM_FRAMES - 1 - k) : k;
        return word[sel*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Sticky overrun: any new result outside IDLE is dropped; a same-edge set beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            OVERRUN <= 1'b0;
        end else if (RESULT_VLD && (state != IDLE)) begin
            OVERRUN <= 1'b1;
        end else if (CLR_OVR) begin
            OVERRUN <= 1'b0;
        end
    end

    // Transfer FSM: capture in IDLE, present frames in SEND, optional idle spacing in GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hold    <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            TX_DATA <= '0;
            TX_VLD  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (RESULT_VLD) begin
                        hold    <= RESULT;
                        idx     <= '0;
                        TX_DATA <= frame_of(RESULT, 0);
                        TX_VLD  <= 1'b1;
                        BUSY    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (TX_VLD && TX_RDY) begin
                        if (idx == LAST_IDX) begin
                            TX_VLD <= 1'b0;
                            BUSY   <= 1'b0;
                            DONE   <= 1'b1;
                            idx    <= '0;
                            state  <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                TX_DATA <= frame_of(hold, int'(idx) + 1);
                            end else begin
                                TX_VLD  <= 1'b0;
                                gap_cnt <= GAP_LOAD;
                                state   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    // idx already points at the next frame; the count ends the gap at 1.
                    if (gap_cnt <= 8'd1) begin
                        gap_cnt <= '0;
                        TX_DATA <= frame_of(hold, int'(idx));
                        TX_VLD  <= 1'b1;
                        state   <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_VLD <= 1'b0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule
